control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired fetch/decode/execute controller for ALUSystem. Sits beside the datapath in
//  CompleteSystem: drives every ALUSystem select/enable from a state counter plus IROut,
//  and latches ALU flags for conditional branches. Unused opcodes execute as NOP.
// PARAMETERS
//  OP_W    4  opcode width, taken from IROut[15:12]
//  INIT_EN 1  1 = issue INIT clear cycle after reset; 0 = start directly in FETCH_L
// PORTS
//  Clock        in   1   system clock; all state updates on posedge
//  Reset        in   1   synchronous, active-high
//  IROut        in   16  instruction register: [15:12] op, [11:10] Rd, [9:8] Rs, [7:0] imm/addr
//  ALUOutFlag   in   4   {Z,C,N,O} from ALU, combinational
//  RF_OutASel, RF_OutBSel, RF_FunSel  out 2 each;  RF_RegSel  out 4 (bit i = R(i+1))
//  ALU_FunSel   out  4;  ARF_OutCSel, ARF_OutDSel, ARF_FunSel  out 2 each
//  ARF_RegSel   out  3   {AR,SP,PC}, active-high;  IR_LH, IR_Enable  out 1;  IR_Funsel  out 2
//  Mem_WR       out  1   1 = write;  Mem_CS  out 1  active-low chip select
//  MuxASel, MuxBSel out 2;  MuxCSel out 1;  Halted out 1;  State out 3
// BEHAVIOUR
//  - Encodings: FunSel 00 dec, 01 inc, 10 load, 11 clear. MuxA/MuxB 00 ALUOut, 01 MemoryOut,
//    10 IROut[7:0], 11 ARF COut. ARF_OutDSel 00 PC, 01 SP, 10 AR.
//  - Idle output (every state not listed): all RegSel/IR_Enable 0, Mem_CS 1, Mem_WR 0, rest 0.
//  - Reset: State=INIT (or FETCH_L if INIT_EN=0), flags=0, Halted=0, outputs idle same cycle.
//    Reset mid-instruction abandons it; no partial writes issued while Reset high.
//  - States (3-bit): INIT=0 FETCH_L=1 FETCH_H=2 EXEC1=3 EXEC2=4 HALT=5 (WAIT=6 optional).
//  - INIT: RF_RegSel=1111, ARF_RegSel=111, FunSel 11 both -> FETCH_L.
//  - FETCH_L: OutDSel=PC, CS=0, IR_LH=0, IR_Enable=1, IR_Funsel=10; PC inc -> FETCH_H.
//  - FETCH_H: same with IR_LH=1 -> EXEC1. Instruction fetch = 2 cycles.
//  - EXEC1 by op (Rd=R(IR[11:10]+1), Rs=R(IR[9:8]+1)):
//     0 LDI: MuxA=10, RF load Rd -> FETCH_L       1 LD: AR<-IMM (MuxB=10) -> EXEC2
//     2 ST : AR<-IMM -> EXEC2                     3 ALU: OutA=Rd, OutB=Rs, ALU_FunSel=IR[7:4],
//       MuxA=00, RF load Rd; flags<=ALUOutFlag at same posedge -> FETCH_L
//     4 BRA: PC<-IMM (MuxB=10) -> FETCH_L         5 BEQ: if latched Z PC<-IMM else no write
//     6 MOV: OutA=Rs, ALU_FunSel=0000 (pass A), MuxA=00, load Rd -> FETCH_L
//     F HLT: -> HALT          others: NOP -> FETCH_L
//  - EXEC2: LD: OutDSel=AR, CS=0, WR=0, MuxA=01, load Rd. ST: OutDSel=AR, OutA=Rd,
//    ALU_FunSel=0000, MuxCSel=0, CS=0, WR=1. Both -> FETCH_L.
//  - Latency: LDI/ALU/BRA/BEQ/MOV/NOP 3 cycles; LD/ST 4 cycles.
//  - HALT: idle outputs, Halted=1; exits only on Reset.
//  - Flags change only on op 3; BEQ in the cycle after an ALU op sees the new Z.
//  - PC wraps 8'hFF->8'h00 (ARF arithmetic, modulo 256); controller does not check.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: extra input Step (1 bit). Each path that would enter FETCH_L
//   enters WAIT (idle outputs); WAIT -> FETCH_L on a cycle with Step=1. Reset and INIT
//   go straight to FETCH_L. Step held high = free run plus 1 cycle per instruction.
//  Undefined: no Step port, no WAIT state, State never equals 6.
// TESTING
//  1 Reset 1 cycle -> State=0, Mem_CS=1, all RegSel 0; next cycle State=1, PC=0.
//  2 mem[0..1]=LDI R1,8'h2A (16'h002A) -> 3 cycles later R1=8'h2A, PC=2, State=1.
//  3 R1=7F,R2=01, ALU add (16'h3140, FunSel 0100) -> R1=80, latched flags N=1,O=1,Z=0.
//  4 ST R1,8'h40 then LD R3,8'h40 -> mem[40]=80 after 4 cycles; R3=80 after next 4.
//  5 SUB R1-R1 gives Z=1; BEQ 8'h10 -> PC=10. Z=0 case -> PC=prev+2, no ARF write.
//  6 HLT (16'hF000) -> Halted=1 held 20 cycles, Mem_CS=1; Reset mid-LD EXEC2 -> no RF write.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute controller driving every ALUSystem select/enable.
// Define SEQ_SINGLE_STEP_EN to add the Step input and the WAIT state between instructions.
module control_sequencer #(
  parameter int OP_W    = 4,
  parameter bit INIT_EN = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC1   = 3'd3,
    S_EXEC2   = 3'd4,
    S_HALT    = 3'd5
`ifdef SEQ_SINGLE_STEP_EN
    , S_WAIT  = 3'd6
`endif
  } state_t;

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t S_RET = S_WAIT;
`else
  localparam state_t S_RET = S_FETCH_L;
`endif

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  localparam logic [1:0] M_ALU = 2'b00;
  localparam logic [1:0] M_MEM = 2'b01;
  localparam logic [1:0] M_IMM = 2'b10;

  localparam logic [1:0] D_PC = 2'b00;
  localparam logic [1:0] D_AR = 2'b10;

  localparam logic [2:0] ARF_PC = 3'b001;
  localparam logic [2:0] ARF_AR = 3'b100;

  localparam logic [OP_W-1:0] OP_LDI = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ST  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ALU = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MOV = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

  typedef struct packed {
    logic [1:0] rf_a;
    logic [1:0] rf_b;
    logic [1:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] alu_fun;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [1:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
  } ctrl_t;

  state_t          state, state_nxt;
  logic [3:0]      flags;
  logic            flag_we;
  ctrl_t           ctl;
  logic [OP_W-1:0] op;
  logic [1:0]      rd, rs;
  logic [3:0]      rd_oh;
  logic            unused_bits;

  assign op          = IROut[15 -: OP_W];
  assign rd          = IROut[11:10];
  assign rs          = IROut[9:8];
  assign rd_oh       = 4'b0001 << rd;
  assign unused_bits = ^{IROut[3:0], flags[2:0]};

  always_ff @(posedge Clock) begin
    if (Reset) state <= INIT_EN ? S_INIT : S_FETCH_L;
    else       state <= state_nxt;
  end

  // {Z,C,N,O} is captured only at the ALU op's write-back edge.
  always_ff @(posedge Clock) begin
    if (Reset)        flags <= '0;
    else if (flag_we) flags <= ALUOutFlag;
  end

  always_comb begin
    state_nxt  = state;
    flag_we    = 1'b0;
    ctl        = '0;
    ctl.mem_cs = 1'b1;
    case (state)
      S_INIT: begin
        ctl.rf_reg  = 4'b1111;
        ctl.rf_fun  = FS_CLR;
        ctl.arf_reg = 3'b111;
        ctl.arf_fun = FS_CLR;
        state_nxt   = S_FETCH_L;
      end
      S_FETCH_L, S_FETCH_H: begin
        ctl.arf_d   = D_PC;
        ctl.mem_cs  = 1'b0;
        ctl.ir_lh   = (state == S_FETCH_H);
        ctl.ir_en   = 1'b1;
        ctl.ir_fun  = FS_LOAD;
        ctl.arf_reg = ARF_PC;
        ctl.arf_fun = FS_INC;
        state_nxt   = (state == S_FETCH_L) ? S_FETCH_H : S_EXEC1;
      end
      S_EXEC1: begin
        state_nxt = S_RET;
        case (op)
          OP_LDI: begin
            ctl.mux_a  = M_IMM;
            ctl.rf_fun = FS_LOAD;
            ctl.rf_reg = rd_oh;
          end
          OP_LD, OP_ST: begin
            ctl.mux_b   = M_IMM;
            ctl.arf_reg = ARF_AR;
            ctl.arf_fun = FS_LOAD;
            state_nxt   = S_EXEC2;
          end
          OP_ALU: begin
            ctl.rf_a    = rd;
            ctl.rf_b    = rs;
            ctl.alu_fun = IROut[7:4];
            ctl.mux_a   = M_ALU;
            ctl.rf_fun  = FS_LOAD;
            ctl.rf_reg  = rd_oh;
            flag_we     = 1'b1;
          end
          OP_BRA, OP_BEQ: begin
            // BEQ tests the Z latched by the most recent ALU op.
            if (op == OP_BRA || flags[3]) begin
              ctl.mux_b   = M_IMM;
              ctl.arf_reg = ARF_PC;
              ctl.arf_fun = FS_LOAD;
            end
          end
          OP_MOV: begin
            ctl.rf_a    = rs;
            ctl.alu_fun = 4'b0000;
            ctl.mux_a   = M_ALU;
            ctl.rf_fun  = FS_LOAD;
            ctl.rf_reg  = rd_oh;
          end
          OP_HLT:  state_nxt = S_HALT;
          default: ;
        endcase
      end
      S_EXEC2: begin
        ctl.arf_d  = D_AR;
        ctl.mem_cs = 1'b0;
        if (op == OP_ST) begin
          ctl.rf_a    = rd;
          ctl.alu_fun = 4'b0000;
          ctl.mux_c   = 1'b0;
          ctl.mem_wr  = 1'b1;
        end else begin
          ctl.mux_a  = M_MEM;
          ctl.rf_fun = FS_LOAD;
          ctl.rf_reg = rd_oh;
        end
        state_nxt = S_RET;
      end
      S_HALT: state_nxt = S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
      S_WAIT: if (Step) state_nxt = S_FETCH_L;
`endif
      default: state_nxt = S_FETCH_L;
    endcase
    // An abandoned instruction must not leak a write while Reset is high.
    if (Reset) begin
      ctl        = '0;
      ctl.mem_cs = 1'b1;
      flag_we    = 1'b0;
    end
  end

  assign RF_OutASel  = ctl.rf_a;
  assign RF_OutBSel  = ctl.rf_b;
  assign RF_FunSel   = ctl.rf_fun;
  assign RF_RegSel   = ctl.rf_reg;
  assign ALU_FunSel  = ctl.alu_fun;
  assign ARF_OutCSel = ctl.arf_c;
  assign ARF_OutDSel = ctl.arf_d;
  assign ARF_FunSel  = ctl.arf_fun;
  assign ARF_RegSel  = ctl.arf_reg;
  assign IR_LH       = ctl.ir_lh;
  assign IR_Enable   = ctl.ir_en;
  assign IR_Funsel   = ctl.ir_fun;
  assign Mem_WR      = ctl.mem_wr;
  assign Mem_CS      = ctl.mem_cs;
  assign MuxASel     = ctl.mux_a;
  assign MuxBSel     = ctl.mux_b;
  assign MuxCSel     = ctl.mux_c;
  assign Halted      = (state == S_HALT) && !Reset;
  assign State       = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: behavioural ALUSystem datapath around the DUT, an
// instruction-level reference model feeding a scoreboard, and a monitor per instruction.
module tb_control_sequencer;

`ifdef SEQ_SINGLE_STEP_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Halted;
  logic [2:0]  State;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset),
`ifdef SEQ_SINGLE_STEP_EN
    .Step(1'b1),
`endif
    .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .Halted(Halted), .State(State)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // 8-bit ALU used by the environment; returns {Z,C,N,O,result}.
  function automatic logic [11:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [8:0] t;
    logic [7:0] r;
    logic       c, o;
    t = '0; c = 1'b0; o = 1'b0;
    case (f)
      4'b0001: r = b;
      4'b0100: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'b0110: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'b0111: r = a & b;
      4'b1000: r = a | b;
      4'b1001: r = a ^ b;
      default: r = a;
    endcase
    return {r == 8'h00, c, r[7], o, r};
  endfunction

  function automatic logic [7:0] fsel(input logic [7:0] q, input logic [1:0] f, input logic [7:0] d);
    case (f)
      2'b00:   return q - 8'd1;
      2'b01:   return q + 8'd1;
      2'b10:   return d;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- behavioural datapath ----------------
  logic [7:0]  rf [4];
  logic [7:0]  pc_r, sp_r, ar_r;
  logic [15:0] ir;
  logic [7:0]  dmem [256];
  logic [7:0]  prog [256];
  logic [7:0]  rmem [256];
  logic        load_req = 1'b0;
  logic [7:0]  out_a, out_b, alu_out, addr, cout, mem_out, mux_a, mux_b, mux_c;
  logic [3:0]  alu_flag;

  always_comb begin
    out_a = rf[RF_OutASel];
    out_b = rf[RF_OutBSel];
    {alu_flag, alu_out} = alu(out_a, out_b, ALU_FunSel);
    case (ARF_OutDSel) 2'b00: addr = pc_r; 2'b01: addr = sp_r; default: addr = ar_r; endcase
    case (ARF_OutCSel) 2'b00: cout = pc_r; 2'b01: cout = sp_r; default: cout = ar_r; endcase
    mem_out = Mem_CS ? 8'h00 : dmem[addr];
    case (MuxASel) 2'b00: mux_a = alu_out; 2'b01: mux_a = mem_out; 2'b10: mux_a = ir[7:0]; default: mux_a = cout; endcase
    case (MuxBSel) 2'b00: mux_b = alu_out; 2'b01: mux_b = mem_out; 2'b10: mux_b = ir[7:0]; default: mux_b = cout; endcase
    mux_c = MuxCSel ? 8'h00 : alu_out;
  end

  assign IROut      = ir;
  assign ALUOutFlag = alu_flag;

  always @(posedge Clock) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) dmem[i] <= prog[i];
      ir <= '0;
    end else begin
      for (int i = 0; i < 4; i++) if (RF_RegSel[i]) rf[i] <= fsel(rf[i], RF_FunSel, mux_a);
      if (ARF_RegSel[0]) pc_r <= fsel(pc_r, ARF_FunSel, mux_b);
      if (ARF_RegSel[1]) sp_r <= fsel(sp_r, ARF_FunSel, mux_b);
      if (ARF_RegSel[2]) ar_r <= fsel(ar_r, ARF_FunSel, mux_b);
      if (IR_Enable && IR_Funsel == 2'b10) begin
        if (IR_LH) ir[15:8] <= mem_out;
        else       ir[7:0]  <= mem_out;
      end
      if (!Mem_CS && Mem_WR) dmem[addr] <= mux_c;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic            halt;
    logic [7:0]      lat;
    logic [3:0][7:0] r;
    logic [7:0]      pc;
    logic [7:0]      ar;
    logic            wr;
    logic [7:0]      wa;
    logic [7:0]      wd;
  } exp_t;

  exp_t sb[$];
  logic mon_en = 1'b0;

  // Executes the program one instruction at a time from the ISA description.
  task automatic ref_run(input int n);
    logic [7:0]  r [4];
    logic [7:0]  pc, pc1, ar, imm;
    logic [1:0]  d, s;
    logic        zf;
    logic [15:0] ins;
    logic [11:0] a;
    exp_t        e;
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    pc = 8'h00; ar = 8'h00; zf = 1'b0;
    for (int k = 0; k < n; k++) begin
      pc1 = pc + 8'd1;
      ins = {rmem[pc1], rmem[pc]};
      pc  = pc + 8'd2;
      d = ins[11:10]; s = ins[9:8]; imm = ins[7:0];
      e = '0;
      e.lat = 8'(3 + SE);
      case (ins[15:12])
        4'h0: r[d] = imm;
        4'h1: begin ar = imm; r[d] = rmem[imm]; e.lat = 8'(4 + SE); end
        4'h2: begin ar = imm; rmem[imm] = r[d]; e.wr = 1'b1; e.wa = imm; e.wd = r[d]; e.lat = 8'(4 + SE); end
        4'h3: begin a = alu(r[d], r[s], ins[7:4]); r[d] = a[7:0]; zf = a[11]; end
        4'h4: pc = imm;
        4'h5: if (zf) pc = imm;
        4'h6: r[d] = r[s];
        4'hF: begin e.halt = 1'b1; e.lat = 8'd3; end
        default: ;
      endcase
      e.r  = {r[3], r[2], r[1], r[0]};
      e.pc = pc;
      e.ar = ar;
      sb.push_back(e);
      if (e.halt) break;
    end
  endtask

  // Monitor: an instruction completes when the DUT next reaches FETCH_L or enters HALT.
  initial begin : monitor
    int   cyc, last;
    bit   started;
    logic [2:0] prev;
    exp_t e;
    cyc = 0; last = 0; started = 0; prev = 3'd0;
    forever begin
      @(negedge Clock);
      cyc++;
      if (Reset || !mon_en) started = 0;
      else if (State == 3'd1 || (State == 3'd5 && prev != 3'd5)) begin
        if (started) begin
          if (sb.size() == 0) chk("sb_unexpected_completion", 32'(State), 32'hFFFF);
          else begin
            e = sb.pop_front();
            chk("kind", 32'(State), e.halt ? 32'd5 : 32'd1);
            chk("latency", 32'(cyc - last), 32'(e.lat));
            chk("regs", {rf[3], rf[2], rf[1], rf[0]}, 32'(e.r));
            chk("pc_ar", {16'h0, pc_r, ar_r}, {16'h0, e.pc, e.ar});
            if (e.halt) chk("halted", 32'(Halted), 32'd1);
            if (e.wr) chk("mem_write", 32'(dmem[e.wa]), 32'(e.wd));
          end
        end
        started = 1;
        last    = cyc;
      end
      prev = State;
    end
  end

  task automatic put(input logic [7:0] a, input logic [15:0] ins);
    logic [7:0] a1;
    a1 = a + 8'd1;
    prog[a]  = ins[7:0];
    prog[a1] = ins[15:8];
  endtask

  task automatic load_prog();
    Reset = 1'b1;
    @(negedge Clock); load_req = 1'b1;
    @(negedge Clock); load_req = 1'b0;
    for (int i = 0; i < 256; i++) rmem[i] = prog[i];
  endtask

  task automatic run_prog(input int n, input bit hold_halt);
    int nmis;
    load_prog();
    sb.delete();
    ref_run(n);
    @(negedge Clock);
    mon_en = 1'b1;
    Reset  = 1'b0;
    for (int k = 0; k < 5 * n + 40 && sb.size() != 0; k++) @(negedge Clock);
    chk("timeout_pending", 32'(sb.size()), 32'd0);
    if (hold_halt)
      for (int k = 0; k < 20; k++) begin
        @(negedge Clock);
        chk("halt_hold", {28'h0, State, Halted}, {28'h0, 3'd5, 1'b1});
        chk("halt_cs", 32'(Mem_CS), 32'd1);
      end
    Reset  = 1'b1;
    mon_en = 1'b0;
    nmis = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== rmem[i]) nmis++;
    chk("mem_final", 32'(nmis), 32'd0);
  endtask

  function automatic logic [3:0] rand_op();
    int s;
    s = $urandom_range(0, 59);
    if (s == 59) return 4'hF;
    case (s % 19)
      0, 1:        return 4'h0;
      2, 3:        return 4'h1;
      4, 5:        return 4'h2;
      6, 7, 8, 9:  return 4'h3;
      10:          return 4'h4;
      11, 12:      return 4'h5;
      13, 14:      return 4'h6;
      15:          return 4'h7;
      16:          return 4'h9;
      17:          return 4'hC;
      default:     return 4'hE;
    endcase
  endfunction

  function automatic logic [3:0] rand_fun();
    case ($urandom_range(0, 6))
      0: return 4'b0000; 1: return 4'b0001; 2: return 4'b0100; 3: return 4'b0110;
      4: return 4'b0111; 5: return 4'b1000; default: return 4'b1001;
    endcase
  endfunction

  initial begin : main
    logic [3:0]  op;
    logic [15:0] ins;
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    repeat (2) @(negedge Clock);

    // reset state and first post-reset cycle
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_idle", {23'h0, RF_RegSel, ARF_RegSel, IR_Enable, Mem_WR},  32'd0);
    chk("rst_cs_halted", {30'h0, Mem_CS, Halted}, 32'd2);
    Reset = 1'b0;
    @(negedge Clock);
    chk("post_rst_state", 32'(State), 32'd1);
    chk("post_rst_pc", 32'(pc_r), 32'd0);
    chk("post_rst_regs", {rf[3], rf[2], rf[1], rf[0]}, 32'd0);

    // directed program: LDI, ALU add, ST/LD, BEQ taken/not, MOV, NOP, BRA, HLT
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    put(8'h00, 16'h002A); put(8'h02, 16'h007F); put(8'h04, 16'h0401);
    put(8'h06, 16'h3140); put(8'h08, 16'h2040); put(8'h0A, 16'h1840);
    put(8'h0C, 16'h3060); put(8'h0E, 16'h5010); put(8'h10, 16'h3160);
    put(8'h12, 16'h5030); put(8'h14, 16'h6E00); put(8'h16, 16'h7000);
    put(8'h18, 16'h4020); put(8'h20, 16'hF000);
    run_prog(40, 1'b1);
    chk("dir_mem40", 32'(dmem[8'h40]), 32'h80);
    chk("dir_r3_r4", {16'h0, rf[3], rf[2]}, 32'h8080);
    chk("dir_r1", 32'(rf[0]), 32'hFF);

    // Reset during LD's EXEC2 must not write Rd
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    put(8'h00, 16'h3060); put(8'h02, 16'h0855); put(8'h04, 16'h1840);
    prog[8'h40] = 8'h99;
    load_prog();
    @(negedge Clock);
    Reset = 1'b0;
    for (int k = 0; k < 40 && State != 3'd4; k++) @(negedge Clock);
    chk("mid_ld_reached", 32'(State), 32'd4);
    chk("mid_ld_active", {27'h0, RF_RegSel, Mem_CS}, {27'h0, 4'b0100, 1'b0});
    Reset = 1'b1;
    #1;
    chk("mid_ld_gated", {26'h0, RF_RegSel, Mem_CS, Mem_WR}, {26'h0, 4'b0000, 1'b1, 1'b0});
    @(negedge Clock);
    chk("mid_ld_r3_kept", 32'(rf[2]), 32'h55);
    chk("mid_ld_state", {28'h0, State, Halted}, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    chk("mid_ld_restart", {16'h0, 5'h0, State, pc_r}, {16'h0, 5'h0, 3'd1, 8'h00});
    repeat (6) @(negedge Clock);

    // flags cleared by reset: BEQ first must fall through
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    put(8'h00, 16'h5010); put(8'h02, 16'hF000); put(8'h10, 16'hF000);
    run_prog(4, 1'b0);

    // randomized programs
    for (int round = 0; round < 4; round++) begin
      for (int a = 0; a < 256; a += 2) begin
        op = rand_op();
        if (op == 4'h3) ins = {op, 4'($urandom), rand_fun(), 4'($urandom)};
        else            ins = {op, 4'($urandom), 8'($urandom)};
        put(8'(a), ins);
      end
      run_prog(120, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
